// File: rtl/spi_adc_reader_pkg.sv
// Shared types and helpers for the serial ADC frame sequencer.
package adc_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // Cycles from the first SETUP cycle through the last HOLD cycle.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned clk_div);
        return clk_div * (2 * data_w + 2);
    endfunction

endpackage

// File: rtl/spi_adc_reader_if.sv
// ADC pin bundle: the reader is master, the ADC (or its model) is slave.
interface spi_adc_reader_if;
    logic cs_n;
    logic sclk;
    logic drdy;
    logic sdo;

    modport master (output cs_n, output sclk, input drdy, input sdo);
    modport slave  (input cs_n, input sclk, output drdy, output sdo);
endinterface

// File: rtl/spi_adc_reader_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input with a registered
// rising-edge pulse one cycle after the synchronised level rises.
module edge_sync #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise
);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;
    logic                rise_q, rise_d;

    // Shift the raw input through the chain and detect the 0->1 level change.
    always_comb begin
        sync_d = SYNC_STG'({sync_q, in});
        prev_d = sync_q[SYNC_STG-1];
        rise_d = sync_q[SYNC_STG-1] & ~prev_q;
    end

    // Synchroniser and edge flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign out  = sync_q[SYNC_STG-1];
    assign rise = rise_q;

endmodule

// File: rtl/spi_adc_reader.sv
// Serial ADC frame sequencer: on each synchronised DRDY rising edge runs one
// CS/SCLK read frame, shifts in DATA_W bits MSB-first and pulses sample_valid.
// Optional feature macro: ADC_RD_OVERRUN_EN adds the sticky overrun output.
module spi_adc_reader
    import adc_rd_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    spi_adc_reader_if.master  adc,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy
`ifdef ADC_RD_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    logic drdy_rise;
    logic sdo_s;
    logic drdy_lvl_unused;
    logic sdo_rise_unused;

    edge_sync #(.SYNC_STG(SYNC_STG)) u_drdy_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (adc.drdy),
        .out  (drdy_lvl_unused),
        .rise (drdy_rise)
    );

    edge_sync #(.SYNC_STG(SYNC_STG)) u_sdo_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (adc.sdo),
        .out  (sdo_s),
        .rise (sdo_rise_unused)
    );

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                div_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // Frame sequencing; registered pin/output values follow the next state.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        sclk_d   = sclk_q;
        sample_d = sample_q;

        unique case (state_q)
            IDLE: begin
                if (drdy_rise && enable) begin
                    state_d = SETUP;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // sclk rises on this edge: capture the bit now.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[DATA_W-2:0], sdo_s};
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_d = DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_n_d  = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
        if (state_d == DONE) begin
            sample_d = shift_q;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sample_q <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign adc.cs_n     = cs_n_q;
    assign adc.sclk     = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

`ifdef ADC_RD_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky flag for DRDY edges dropped outside IDLE; set beats clear.
    always_comb begin
        overrun_d = overrun_q;
        if (!enable && (state_q == IDLE)) begin
            overrun_d = 1'b0;
        end
        if (drdy_rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_adc_reader.sv
// Scoreboard bench for spi_adc_reader: default instance plus a DATA_W=2,
// CLK_DIV=3 corner instance, each driven by a simple shift-out ADC model.
module tb_spi_adc_reader;
    import adc_rd_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned CD  = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned DW2 = 2;
    localparam int unsigned CD2 = 3;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    always #5 clk = ~clk;

    spi_adc_reader_if pins();
    spi_adc_reader_if pins2();

    logic [DW-1:0]  sample;
    logic           sample_valid, busy;
    logic [DW2-1:0] sample2;
    logic           sample_valid2, busy2;
`ifdef ADC_RD_OVERRUN_EN
    logic overrun, overrun2;
`endif

    spi_adc_reader #(.DATA_W(DW), .CLK_DIV(CD), .SYNC_STG(SS)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc          (pins),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
`ifdef ADC_RD_OVERRUN_EN
        ,
        .overrun      (overrun)
`endif
    );

    spi_adc_reader #(.DATA_W(DW2), .CLK_DIV(CD2), .SYNC_STG(SS)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc          (pins2),
        .sample       (sample2),
        .sample_valid (sample_valid2),
        .busy         (busy2)
`ifdef ADC_RD_OVERRUN_EN
        ,
        .overrun      (overrun2)
`endif
    );

    // ADC models: present MSB on CS fall, advance one bit on each SCLK fall.
    logic [DW-1:0]  adc_word, adc_sr;
    logic [DW2-1:0] adc_word2, adc_sr2;

    always @(negedge pins.cs_n) begin
        adc_sr   = adc_word;
        pins.sdo = adc_sr[DW-1];
    end
    always @(negedge pins.sclk) begin
        if (pins.cs_n === 1'b0) begin
            adc_sr   = adc_sr << 1;
            pins.sdo = adc_sr[DW-1];
        end
    end
    always @(negedge pins2.cs_n) begin
        adc_sr2   = adc_word2;
        pins2.sdo = adc_sr2[DW2-1];
    end
    always @(negedge pins2.sclk) begin
        if (pins2.cs_n === 1'b0) begin
            adc_sr2   = adc_sr2 << 1;
            pins2.sdo = adc_sr2[DW2-1];
        end
    end

    int cyc = 0;
    int sclk_rises = 0;
    int sclk2_rises = 0;
    int valid_cnt = 0;
    int tests = 0;
    int fails = 0;

    logic [DW-1:0]  exp_q[$];
    logic [DW2-1:0] exp2_q[$];

    always @(posedge clk) cyc++;
    always @(posedge pins.sclk) sclk_rises++;
    always @(posedge pins2.sclk) sclk2_rises++;
    always @(posedge clk) if (sample_valid === 1'b1) valid_cnt++;

    task automatic test_reset();
        int bad;
        rst = 1'b1; enable = 1'b1;
        pins.drdy = 1'b0; pins.sdo = 1'b0; pins2.drdy = 1'b0; pins2.sdo = 1'b0;
        adc_word = '0; adc_word2 = '0;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pins.drdy = ~pins.drdy; pins2.drdy = ~pins2.drdy;
            @(negedge clk);
            tests++;
            if (pins.cs_n !== 1'b1 || pins.sclk !== 1'b0 || sample !== '0 ||
                sample_valid !== 1'b0 || busy !== 1'b0 || pins2.cs_n !== 1'b1) begin
                fails++;
                $display("FAIL reset_state cyc%0d: cs_n=%b sclk=%b sample=%h valid=%b busy=%b cs_n2=%b, required 1 0 0000 0 0 1",
                         i, pins.cs_n, pins.sclk, sample, sample_valid, busy, pins2.cs_n);
            end
`ifdef ADC_RD_OVERRUN_EN
            tests++;
            if (overrun !== 1'b0) begin
                fails++;
                $display("FAIL reset_overrun: got %b required 0", overrun);
            end
`endif
        end
        pins.drdy = 1'b0; pins2.drdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pins.cs_n !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_no_frame: %0d cycles with activity, required 0", bad);
        end
    endtask

    // One frame on the default instance; re_rise>0 re-raises drdy that many
    // cycles after the start edge to exercise the ignored-edge path.
    task automatic run_frame(input logic [DW-1:0] word, input int re_rise);
        int n0, t_rise, cs_cyc, s0, got;
        logic [DW-1:0] exp;
        adc_word = word;
        exp_q.push_back(word);
        @(negedge clk);
        pins.drdy = 1'b0;
        repeat (4) @(negedge clk);
        pins.drdy = 1'b1;
        n0 = cyc; t_rise = n0 + SS + 1; s0 = sclk_rises; cs_cyc = -1; got = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            @(negedge clk);
            if (re_rise > 0 && cyc == t_rise + re_rise / 2) pins.drdy = 1'b0;
            if (re_rise > 0 && cyc == t_rise + re_rise) pins.drdy = 1'b1;
            if (cs_cyc < 0 && pins.cs_n === 1'b0) cs_cyc = cyc;
            if (sample_valid === 1'b1) begin
                got = 1;
                exp = exp_q.pop_front();
                tests++;
                if (sample !== exp) begin
                    fails++;
                    $display("FAIL frame_sample: got %h required %h", sample, exp);
                end
                tests++;
                if (cyc != t_rise + 1 + int'(frame_len(DW, CD))) begin
                    fails++;
                    $display("FAIL frame_latency: valid at T+%0d required T+%0d",
                             cyc - t_rise, 1 + frame_len(DW, CD));
                end
                tests++;
                if (sclk_rises - s0 != DW) begin
                    fails++;
                    $display("FAIL frame_sclk_count: got %0d required %0d", sclk_rises - s0, DW);
                end
                tests++;
                if (cs_cyc != t_rise + 1 || busy !== 1'b1 || pins.cs_n !== 1'b1) begin
                    fails++;
                    $display("FAIL frame_cs_busy: cs_n low at T+%0d (required T+1), busy=%b cs_n=%b (required 1 1)",
                             cs_cyc - t_rise, busy, pins.cs_n);
                end
            end
        end
        if (got == 0) begin
            tests++; fails++;
            $display("FAIL frame_timeout: no sample_valid within 400 cycles, required one");
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || pins.cs_n !== 1'b1) begin
            fails++;
            $display("FAIL frame_end: valid=%b busy=%b cs_n=%b required 0 0 1",
                     sample_valid, busy, pins.cs_n);
        end
    endtask

    task automatic test_single();
        run_frame(16'hA5C3, 0);
        run_frame(16'h8001, 0);
    endtask

    task automatic test_gating();
        int bad, v0;
        enable = 1'b0;
        pins.drdy = 1'b0;
        repeat (4) @(negedge clk);
        pins.drdy = 1'b1;
        v0 = valid_cnt; bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pins.cs_n !== 1'b1 || sample_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || valid_cnt != v0) begin
            fails++;
            $display("FAIL gating_disabled: %0d active cycles, %0d valids, required 0 0",
                     bad, valid_cnt - v0);
        end
        enable = 1'b1;
        run_frame(16'h3C5A, 0);
    endtask

    task automatic test_edge_during_frame();
        int v0;
        v0 = valid_cnt;
        run_frame(16'h1234, 40);
        repeat (200) @(negedge clk);
        tests++;
        if (valid_cnt - v0 != 1) begin
            fails++;
            $display("FAIL edge_one_frame: got %0d valid pulses required 1", valid_cnt - v0);
        end
`ifdef ADC_RD_OVERRUN_EN
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
`endif
        pins.drdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s0, v0, reached;
        adc_word = 16'hFFFF;
        @(negedge clk);
        pins.drdy = 1'b0;
        repeat (4) @(negedge clk);
        pins.drdy = 1'b1;
        s0 = sclk_rises; reached = 0;
        for (int i = 0; i < 300 && reached == 0; i++) begin
            @(negedge clk);
            if (sclk_rises - s0 == 8) reached = 1;
        end
        tests++;
        if (reached == 0) begin
            fails++;
            $display("FAIL rstmid_reach: sclk rises %0d required 8", sclk_rises - s0);
        end
        rst = 1'b1;
        v0 = valid_cnt;
        @(negedge clk);
        tests++;
        if (pins.cs_n !== 1'b1 || pins.sclk !== 1'b0 || sample !== '0 ||
            sample_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_state: cs_n=%b sclk=%b sample=%h valid=%b busy=%b required 1 0 0000 0 0",
                     pins.cs_n, pins.sclk, sample, sample_valid, busy);
        end
        rst = 1'b0;
        pins.drdy = 1'b0;
        repeat (200) @(negedge clk);
        tests++;
        if (valid_cnt != v0 || sample !== '0) begin
            fails++;
            $display("FAIL rstmid_no_valid: %0d valids sample=%h required 0 0000",
                     valid_cnt - v0, sample);
        end
    endtask

    task automatic test_corner();
        int n0, t_rise, s0, got;
        logic [DW2-1:0] exp;
        adc_word2 = 2'b10;
        exp2_q.push_back(2'b10);
        @(negedge clk);
        pins2.drdy = 1'b1;
        n0 = cyc; t_rise = n0 + SS + 1; s0 = sclk2_rises; got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (sample_valid2 === 1'b1) begin
                got = 1;
                exp = exp2_q.pop_front();
                tests++;
                if (sample2 !== exp) begin
                    fails++;
                    $display("FAIL corner_sample: got %b required %b", sample2, exp);
                end
                tests++;
                if (cyc != t_rise + 1 + int'(frame_len(DW2, CD2))) begin
                    fails++;
                    $display("FAIL corner_latency: valid at T+%0d required T+%0d",
                             cyc - t_rise, 1 + frame_len(DW2, CD2));
                end
                tests++;
                if (sclk2_rises - s0 != DW2) begin
                    fails++;
                    $display("FAIL corner_sclk_count: got %0d required %0d", sclk2_rises - s0, DW2);
                end
            end
        end
        if (got == 0) begin
            tests++; fails++;
            $display("FAIL corner_timeout: no sample_valid within 100 cycles, required one");
            void'(exp2_q.pop_front());
        end
        pins2.drdy = 1'b0;
        @(negedge clk);
        tests++;
        if (sample_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL corner_end: valid=%b busy=%b required 0 0", sample_valid2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gating();
        test_edge_during_frame();
        test_reset_mid();
        test_corner();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
